// File: rtl/dram_line_controller_if.sv
// Request/response bundle between the L1 cache controller (master) and the DRAM line stage (slave).
interface dram_line_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
);
    logic                  dram_cs;
    logic                  dram_we;
    logic [ADDR_WIDTH-1:0] dram_addr;
    logic [LINE_WIDTH-1:0] dram_wdata;
    logic [LINE_WIDTH-1:0] dram_rdata;
    logic                  dram_ack;
    logic                  dram_busy;

    modport master (
        output dram_cs, dram_we, dram_addr, dram_wdata,
        input  dram_rdata, dram_ack, dram_busy
    );

    modport slave (
        input  dram_cs, dram_we, dram_addr, dram_wdata,
        output dram_rdata, dram_ack, dram_busy
    );
endinterface

// File: rtl/dram_line_controller.sv
// Fixed-latency main-memory stage: latches one line request, answers with a one-cycle ack
// LATENCY cycles later, and holds the backing line store.
module dram_line_controller #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LINE_BYTES  = 32,
    parameter int unsigned LINE_WIDTH  = 8 * LINE_BYTES,
    parameter int unsigned DEPTH_LINES = 512,
    parameter int unsigned LATENCY     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    dram_line_controller_if.slave   bus
);

    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  mem_wr_c;

    // Backing store powers up zeroed and deliberately survives rst, like real DRAM contents.
    logic [LINE_WIDTH-1:0] mem_q [DEPTH_LINES] = '{default: '0};

    // Offset and tag bits above the index are don't-care: addresses alias modulo the array size.
    logic unused_addr_c;
    assign unused_addr_c = ^bus.dram_addr;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = ack_q;
        busy_d   = busy_q;
        mem_wr_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.dram_cs) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                    we_d    = bus.dram_we;
                    idx_d   = bus.dram_addr[OFF_W +: IDX_W];
                    wdata_d = bus.dram_wdata;
                    busy_d  = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d  = S_ACK;
                    ack_d    = 1'b1;
                    mem_wr_c = we_q;
                    if (!we_q) begin
                        rdata_d = mem_q[idx_q];
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Commit only from WAIT, so a reset mid-request leaves the array untouched.
    always_ff @(posedge clk) begin
        if (mem_wr_c) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.dram_rdata = rdata_q;
    assign bus.dram_ack   = ack_q;
    assign bus.dram_busy  = busy_q;

endmodule

// File: tb/tb_dram_line_controller.sv
// Scoreboard bench for dram_line_controller: a LATENCY=10 instance and a LATENCY=1 instance.
module tb_dram_line_controller;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    typedef struct {
        bit          rd;
        logic [LW-1:0] data;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic [LW-1:0] pat_a5;

    dram_line_controller_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) if0 ();
    dram_line_controller_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) if1 ();

    dram_line_controller #(.ADDR_WIDTH(AW), .LINE_BYTES(32), .LINE_WIDTH(LW),
                           .DEPTH_LINES(512), .LATENCY(10)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave));

    dram_line_controller #(.ADDR_WIDTH(AW), .LINE_BYTES(32), .LINE_WIDTH(LW),
                           .DEPTH_LINES(512), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every ack must match the head of its queue in cycle and data.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst && if0.dram_ack) begin
            if (q0.size() == 0) begin
                chk("u0_spurious_ack", LW'(if0.dram_ack), LW'(0));
            end else begin
                e = q0.pop_front();
                chk("u0_ack_cycle", LW'(cyc), LW'(e.cyc));
                if (e.rd) chk("u0_rdata", if0.dram_rdata, e.data);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && if1.dram_ack) begin
            if (q1.size() == 0) begin
                chk("u1_spurious_ack", LW'(if1.dram_ack), LW'(0));
            end else begin
                e = q1.pop_front();
                chk("u1_ack_cycle", LW'(cyc), LW'(e.cyc));
                if (e.rd) chk("u1_rdata", if1.dram_rdata, e.data);
            end
        end
    end

    function automatic logic get_busy(input int id);
        return (id == 0) ? if0.dram_busy : if1.dram_busy;
    endfunction

    task automatic drive(input int id, input bit cs, input bit we, input logic [AW-1:0] a,
                         input logic [LW-1:0] d);
        if (id == 0) begin
            if0.dram_cs = cs; if0.dram_we = we; if0.dram_addr = a; if0.dram_wdata = d;
        end else begin
            if1.dram_cs = cs; if1.dram_we = we; if1.dram_addr = a; if1.dram_wdata = d;
        end
    endtask

    task automatic push(input int id, input bit rd, input logic [LW-1:0] d, input int unsigned c);
        exp_t e;
        e.rd = rd; e.data = d; e.cyc = c;
        if (id == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Call at a negedge with the DUT idle; returns just after the acceptance edge.
    task automatic issue(input int id, input bit we, input logic [AW-1:0] a,
                         input logic [LW-1:0] d, input bit expect_ack, output int unsigned e0);
        int unsigned lat;
        lat = (id == 0) ? 10 : 1;
        drive(id, 1'b1, we, a, d);
        @(posedge clk); #1;
        e0 = cyc;
        drive(id, 1'b0, we, a, d);
        chk((id == 0) ? "u0_busy_rise" : "u1_busy_rise", LW'(get_busy(id)), LW'(1));
        if (expect_ack) push(id, !we, d, e0 + lat);
    endtask

    task automatic wait_idle(input int id);
        @(negedge clk);
        for (int i = 0; i < 40 && get_busy(id); i++) @(negedge clk);
        if (get_busy(id)) chk("idle_timeout", LW'(get_busy(id)), LW'(0));
    endtask

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int unsigned e0, e1;
        pat_a5 = {32{8'hA5}};
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Reset defaults
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("u0_rst_ack",   LW'(if0.dram_ack),  LW'(0));
        chk("u0_rst_busy",  LW'(if0.dram_busy), LW'(0));
        chk("u0_rst_rdata", if0.dram_rdata,     LW'(0));
        chk("u1_rst_ack",   LW'(if1.dram_ack),  LW'(0));
        chk("u1_rst_busy",  LW'(if1.dram_busy), LW'(0));
        chk("u1_rst_rdata", if1.dram_rdata,     LW'(0));

        // Write then read of the same line through a different offset
        issue(0, 1'b1, 32'h0000_0040, pat_a5, 1'b1, e0);
        wait_idle(0);
        issue(0, 1'b0, 32'h0000_005C, pat_a5, 1'b1, e1);
        chk("read_accept_gap", LW'(e1 - e0), LW'(12));
        wait_idle(0);

        // Wrap-around aliasing; a write must not disturb the held read data
        issue(0, 1'b1, 32'h0000_0000, LW'(32'h1234), 1'b1, e0);
        wait_idle(0);
        chk("rdata_hold_after_write", if0.dram_rdata, pat_a5);
        issue(0, 1'b0, 32'h0000_4000, LW'(32'h1234), 1'b1, e0);
        wait_idle(0);

        // Reset in the middle of a write to line 3
        issue(0, 1'b1, 32'h0000_0060, LW'(32'hFFFF), 1'b0, e0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy",  LW'(if0.dram_busy), LW'(0));
        chk("midrst_ack",   LW'(if0.dram_ack),  LW'(0));
        chk("midrst_rdata", if0.dram_rdata,     LW'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrst_still_idle", LW'(if0.dram_busy), LW'(0));
        issue(0, 1'b0, 32'h0000_0060, LW'(0), 1'b1, e0);
        wait_idle(0);

        // cs held high: back-to-back reads every 12 cycles, address wiggled during WAIT
        drive(0, 1'b1, 1'b0, 32'h0000_0040, '0);
        @(posedge clk); #1;
        e0 = cyc;
        push(0, 1'b1, pat_a5, e0 + 10);
        push(0, 1'b1, pat_a5, e0 + 22);
        push(0, 1'b1, pat_a5, e0 + 34);
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(posedge clk); #1;
            if0.dram_addr = 32'h0000_0060;
            repeat (5) @(posedge clk); #1;
            if0.dram_addr = 32'h0000_0040;
            if (k == 2) begin
                if0.dram_cs = 1'b0;
            end else begin
                repeat (4) @(posedge clk); #1;
                chk("held_cs_reaccept", LW'(if0.dram_busy), LW'(1));
            end
        end
        wait_idle(0);

        // LATENCY=1 instance: write, then held-cs reads at E0+1 and E0+4
        issue(1, 1'b1, 32'h0000_00A0, LW'(32'hBEEF), 1'b1, e0);
        wait_idle(1);
        drive(1, 1'b1, 1'b0, 32'h0000_00A0, '0);
        @(posedge clk); #1;
        e0 = cyc;
        push(1, 1'b1, LW'(32'hBEEF), e0 + 1);
        push(1, 1'b1, LW'(32'hBEEF), e0 + 4);
        repeat (3) @(posedge clk); #1;
        if1.dram_cs = 1'b0;
        chk("lat1_reaccept_busy", LW'(if1.dram_busy), LW'(1));
        wait_idle(1);

        repeat (3) @(negedge clk);
        chk("u0_sb_drained", LW'(q0.size()), LW'(0));
        chk("u1_sb_drained", LW'(q1.size()), LW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
